// File: rtl/hls_seq_pkg.sv
// Shared types for the HLS run sequencer: FSM state encoding and result status codes.
package hls_seq_pkg;

  localparam int unsigned StatusW = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRST,
    ST_START,
    ST_WAIT,
    ST_REPORT
  } seq_state_e;

  typedef enum logic [StatusW-1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORTED = 2'b10
  } seq_status_e;

endpackage

// File: rtl/hls_seq_result_fifo.sv
// Shift-register result FIFO: the head always lives in entry 0 so the read side is
// driven straight from flops. Push while full is accepted when a pop happens the same cycle.
module hls_seq_result_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             wr_ready_c,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             valid_q;
  logic             pop;
  logic             push;
  logic [IdxW-1:0]  wr_idx;

  assign pop        = valid_q & rready_i;
  assign wr_ready_c = (count_q != CntW'(DEPTH)) || pop;
  assign push       = push_i & wr_ready_c;
  // Write slot moves down by one when the head is leaving in the same cycle.
  assign wr_idx     = IdxW'(count_q - CntW'(pop));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          mem_q[i] <= mem_q[i+1];
        end
      end
      if (push) begin
        mem_q[wr_idx] <= wdata_i;
      end
    end
  end

  assign rvalid_o = valid_q;
  assign rdata_o  = mem_q[0];

endmodule

// File: rtl/hls_run_sequencer.sv
// Batch sequencer for an HLS accelerator: reset, start, time and report each run.
// Optional watchdog enabled by defining HLS_SEQ_TIMEOUT_EN.
module hls_run_sequencer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RUNS_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 200000000,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RUNS_W-1:0] cmd_runs,
  input  logic              abort,
  output logic              dut_reset,
  output logic              start_port,
  input  logic              done_port,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [1:0]        res_status,
  output logic              busy,
  output logic [RUNS_W-1:0] runs_left
);

  import hls_seq_pkg::*;

  localparam int unsigned ResW = CNT_W + StatusW;
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TmoCnt = CNT_W'(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RstW-1:0]   rcnt_q, rcnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  rcyc_q, rcyc_d;
  seq_status_e       rstat_q, rstat_d;
  logic              ready_q, busy_q, drst_n_q, start_q;

  logic              push;
  logic              push_ok;
  logic [ResW-1:0]   fifo_rdata;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign push    = (state_q == ST_REPORT);

  always_comb begin
    state_d = state_q;
    runs_d  = runs_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    rcyc_d  = rcyc_q;
    rstat_d = rstat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q && (cmd_runs != '0)) begin
          runs_d  = cmd_runs;
          last_d  = 1'b0;
          rcnt_d  = '0;
          cnt_d   = '0;
          state_d = ST_DRST;
        end
      end
      ST_DRST: begin
        if (abort) begin
          rcyc_d  = cnt_q;
          rstat_d = STAT_ABORTED;
          runs_d  = '0;
          last_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (rcnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d = ST_START;
        end else begin
          rcnt_d = rcnt_q + RstW'(1);
        end
      end
      ST_START: begin
        cnt_d = CNT_W'(1);
        if (abort) begin
          rcyc_d  = CNT_W'(1);
          rstat_d = STAT_ABORTED;
          runs_d  = '0;
          last_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (done_port) begin
          rcyc_d  = CNT_W'(1);
          rstat_d = STAT_OK;
          state_d = ST_REPORT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          rcyc_d  = cnt_q;
          rstat_d = STAT_ABORTED;
          runs_d  = '0;
          last_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (done_port) begin
          rcyc_d  = cnt_q;
          rstat_d = STAT_OK;
          state_d = ST_REPORT;
`ifdef HLS_SEQ_TIMEOUT_EN
        end else if (cnt_q == TmoCnt) begin
          rcyc_d  = TmoCnt;
          rstat_d = STAT_TIMEOUT;
          runs_d  = '0;
          last_d  = 1'b1;
          state_d = ST_REPORT;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_REPORT: begin
        // An abort here only truncates the batch; the pending result still goes out.
        if (abort) begin
          last_d = 1'b1;
        end
        if (push_ok) begin
          if (last_q || abort || (runs_q <= RUNS_W'(1))) begin
            runs_d  = '0;
            state_d = ST_IDLE;
          end else begin
            runs_d  = runs_q - RUNS_W'(1);
            rcnt_d  = '0;
            cnt_d   = '0;
            state_d = ST_DRST;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are registered decodes of the next state so they align with state_q.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      runs_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      last_q   <= 1'b0;
      rcyc_q   <= '0;
      rstat_q  <= STAT_OK;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      drst_n_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      runs_q   <= runs_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      last_q   <= last_d;
      rcyc_q   <= rcyc_d;
      rstat_q  <= rstat_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      drst_n_q <= (state_d != ST_DRST);
      start_q  <= (state_d == ST_START);
    end
  end

`ifndef HLS_SEQ_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TmoCnt;
`endif

  logic fifo_wr_ready;

  hls_seq_result_fifo #(
    .WIDTH (ResW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .push_i     (push),
    .wdata_i    ({rstat_q, rcyc_q}),
    .wr_ready_c (fifo_wr_ready),
    .rvalid_o   (res_valid),
    .rready_i   (res_ready),
    .rdata_o    (fifo_rdata)
  );

  assign push_ok    = push & fifo_wr_ready;
  assign res_cycles = fifo_rdata[CNT_W-1:0];
  assign res_status = fifo_rdata[ResW-1 -: StatusW];
  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign dut_reset  = drst_n_q;
  assign start_port = start_q;
  assign runs_left  = runs_q;

endmodule
